// File: rtl/legv8_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module : legv8_mem_pkg
// Brief  : Store-size encodings, store FSM states and lane helpers for the
//          LEGv8 data-memory store path.
// Rev    : 1.0
// ============================================================================
package legv8_mem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    localparam int DW_BYTES = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WRITE   = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Lanes covered by a store of the given size, starting at lane 0.
    function automatic logic [7:0] size_lanes(input logic [1:0] size);
        case (size)
            SZ_B:    return 8'h01;
            SZ_H:    return 8'h03;
            SZ_W:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    // Address bits that must be zero for a naturally aligned store.
    function automatic logic [2:0] size_low_mask(input logic [1:0] size);
        case (size)
            SZ_B:    return 3'b000;
            SZ_H:    return 3'b001;
            SZ_W:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/store_narrow_rmw_if.sv
`default_nettype none
// ============================================================================
// Module : store_narrow_rmw_if
// Brief  : Request and data-memory bundle for the store width narrower.
// Rev    : 1.0
// ============================================================================
interface store_narrow_rmw_if #(
    parameter int ADDR_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [63:0]       req_data;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_rvalid;
    logic [63:0]       mem_rdata;
    logic              mem_wr;
    logic [63:0]       mem_wdata;
    logic              done;
    logic              misalign_err;

    // Environment side: issues requests and answers memory reads.
    modport master (
        output req_valid, req_addr, req_data, req_size, mem_rvalid, mem_rdata,
        input  req_ready, mem_addr, mem_rd, mem_wr, mem_wdata, done, misalign_err
    );

    // Store block side.
    modport slave (
        input  req_valid, req_addr, req_data, req_size, mem_rvalid, mem_rdata,
        output req_ready, mem_addr, mem_rd, mem_wr, mem_wdata, done, misalign_err
    );
endinterface
`default_nettype wire

// File: rtl/store_narrow_rmw_lane_merge.sv
`default_nettype none
// ============================================================================
// Module : store_lane_merge
// Brief  : Combinational little-endian byte-lane merge of narrowed store data
//          into an existing doubleword.
// Rev    : 1.0
// ============================================================================
module store_lane_merge
    import legv8_mem_pkg::*;
(
    input  wire logic [63:0] old_i,
    input  wire logic [63:0] new_i,
    input  wire logic [1:0]  size_i,
    input  wire logic [2:0]  offset_i,
    output logic      [63:0] merged_o,
    output logic      [7:0]  mask_o
);
    logic [63:0] shifted;
    logic [63:0] byte_mask;

    // Source bits above the store width land in masked-off lanes, giving truncation.
    always_comb begin
        mask_o    = size_lanes(size_i) << offset_i;
        shifted   = new_i << {offset_i, 3'b000};
        byte_mask = '0;
        for (int k = 0; k < DW_BYTES; k++) begin
            byte_mask[8*k +: 8] = {8{mask_o[k]}};
        end
        merged_o  = (old_i & ~byte_mask) | (shifted & byte_mask);
    end
endmodule
`default_nettype wire

// File: rtl/store_narrow_rmw.sv
`default_nettype none
// ============================================================================
// Module : store_narrow_rmw
// Brief  : Store-side width narrower; read-modify-write for byte/half/word
//          stores, direct write for doubleword. Option macro:
//          STORE_NARROW_ALIGN_CHECK_EN (reject misaligned stores).
// Rev    : 1.0
// ============================================================================
module store_narrow_rmw
    import legv8_mem_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    store_narrow_rmw_if.slave bus
);
    state_t            state_q, state_d;
    logic [ADDR_W-4:0] addr_hi_q;
    logic [2:0]        offset_q;
    logic [1:0]        size_q;
    logic [63:0]       data_q;
    logic [63:0]       wdata_q;
    logic              err_q;

    logic              accept;
    logic              misalign;
    logic [2:0]        low_mask;
    logic [63:0]       merged;
    logic [7:0]        lane_mask_unused;

    assign accept   = (state_q == ST_IDLE) && bus.req_valid;
    assign low_mask = size_low_mask(bus.req_size);

`ifdef STORE_NARROW_ALIGN_CHECK_EN
    assign misalign = |(bus.req_addr[2:0] & low_mask);
`else
    assign misalign = 1'b0;
`endif

    store_lane_merge u_merge (
        .old_i    (bus.mem_rdata),
        .new_i    (data_q),
        .size_i   (size_q),
        .offset_i (offset_q),
        .merged_o (merged),
        .mask_o   (lane_mask_unused)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    // A rejected request still passes through DONE so req_ready drops for a cycle.
                    if (misalign)                  state_d = ST_DONE;
                    else if (bus.req_size == SZ_D) state_d = ST_WRITE;
                    else                           state_d = ST_RD_REQ;
                end
            end
            ST_RD_REQ:  state_d = ST_RD_WAIT;
            ST_RD_WAIT: if (bus.mem_rvalid) state_d = ST_WRITE;
            ST_WRITE:   state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = (state_q == ST_IDLE);
        bus.mem_rd    = (state_q == ST_RD_REQ);
        bus.mem_wr    = (state_q == ST_WRITE);
        bus.done      = (state_q == ST_DONE) && !err_q;
`ifdef STORE_NARROW_ALIGN_CHECK_EN
        bus.misalign_err = (state_q == ST_DONE) && err_q;
`else
        bus.misalign_err = 1'b0;
`endif
        bus.mem_addr  = {addr_hi_q, 3'b000};
        bus.mem_wdata = wdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_hi_q <= '0;
            offset_q  <= '0;
            size_q    <= SZ_B;
            data_q    <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
        end else if (accept) begin
            addr_hi_q <= bus.req_addr[ADDR_W-1:3];
            offset_q  <= bus.req_addr[2:0] & ~low_mask;
            size_q    <= bus.req_size;
            data_q    <= bus.req_data;
            err_q     <= misalign;
            if (bus.req_size == SZ_D && !misalign) begin
                wdata_q <= bus.req_data;
            end
        end else if (state_q == ST_RD_WAIT && bus.mem_rvalid) begin
            wdata_q <= merged;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_store_narrow_rmw.sv
`default_nettype none
// ============================================================================
// Module : tb_store_narrow_rmw
// Brief  : Directed self-checking bench for store_narrow_rmw.
// Rev    : 1.0
// ============================================================================
module tb_store_narrow_rmw;
    logic clk;
    logic rst_n;

    store_narrow_rmw_if #(.ADDR_W(64)) sif ();

    store_narrow_rmw #(.ADDR_W(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_bad;

    int rd_n, wr_n, done_n, err_n;
    int wr_c, done_c, err_c, rdy_c, rdy_early;
    logic [63:0] wr_data, wr_addr, rd_addr;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and observe cycles T+1.. until req_ready returns.
    task automatic run_store(input logic [63:0] a, input logic [63:0] d, input logic [1:0] sz,
                             input logic [63:0] rd, input int rdelay);
        int rv_at;
        rv_at = -1;
        rd_n = 0; wr_n = 0; done_n = 0; err_n = 0;
        wr_c = -1; done_c = -1; err_c = -1; rdy_c = -1; rdy_early = 0;
        wr_data = '0; wr_addr = '0; rd_addr = '0;
        sif.req_valid = 1'b1;
        sif.req_addr  = a;
        sif.req_data  = d;
        sif.req_size  = sz;
        check_eq("ready_before_req", {63'b0, sif.req_ready}, 64'd1);
        tick();
        sif.req_valid = 1'b0;
        sif.req_data  = '0;
        for (int c = 1; c <= 40; c++) begin
            sif.mem_rvalid = (c == rv_at);
            sif.mem_rdata  = (c == rv_at) ? rd : 64'h0;
            if (sif.mem_rd) begin rd_n++; rd_addr = sif.mem_addr; rv_at = c + rdelay; end
            if (sif.mem_wr) begin wr_n++; wr_c = c; wr_data = sif.mem_wdata; wr_addr = sif.mem_addr; end
            if (sif.done) begin done_n++; done_c = c; end
            if (sif.misalign_err) begin err_n++; err_c = c; end
            if (sif.req_ready) begin
                if (done_n == 0 && err_n == 0) rdy_early = 1;
                rdy_c = c;
                break;
            end
            tick();
        end
        sif.mem_rvalid = 1'b0;
        sif.mem_rdata  = '0;
    endtask

    initial begin
        int spur_wr;
        n_chk = 0;
        n_bad = 0;
        rst_n = 1'b0;
        sif.req_valid  = 1'b0;
        sif.req_addr   = '0;
        sif.req_data   = '0;
        sif.req_size   = 2'b00;
        sif.mem_rvalid = 1'b0;
        sif.mem_rdata  = '0;
        repeat (3) tick();

        check_eq("rst_ready", {63'b0, sif.req_ready}, 64'd1);
        check_eq("rst_strobes", {60'b0, sif.mem_rd, sif.mem_wr, sif.done, sif.misalign_err}, 64'd0);
        check_eq("rst_addr", sif.mem_addr, 64'd0);
        check_eq("rst_wdata", sif.mem_wdata, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // STURB into lane 3
        run_store(64'h1003, 64'hFFFF_FFFF_FFFF_FFAB, 2'b00, 64'h1122_3344_5566_7788, 1);
        check_eq("b_rd_n", rd_n, 1);
        check_eq("b_rd_addr", rd_addr, 64'h1000);
        check_eq("b_wr_n", wr_n, 1);
        check_eq("b_wr_cyc", wr_c, 3);
        check_eq("b_wdata", wr_data, 64'h1122_3344_AB66_7788);
        check_eq("b_wr_addr", wr_addr, 64'h1000);
        check_eq("b_done_n", done_n, 1);
        check_eq("b_done_cyc", done_c, 4);
        check_eq("b_ready_cyc", rdy_c, 5);
        check_eq("b_ready_early", rdy_early, 0);

        // STUR direct write
        run_store(64'h2000, 64'hDEAD_BEEF_0123_4567, 2'b11, 64'h0, 1);
        check_eq("d_rd_n", rd_n, 0);
        check_eq("d_wr_cyc", wr_c, 1);
        check_eq("d_wdata", wr_data, 64'hDEAD_BEEF_0123_4567);
        check_eq("d_wr_addr", wr_addr, 64'h2000);
        check_eq("d_done_cyc", done_c, 2);
        check_eq("d_ready_cyc", rdy_c, 3);

        // STURW with a slow read response
        run_store(64'h000C, 64'h0000_0000_CAFE_F00D, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 5);
        check_eq("w_rd_n", rd_n, 1);
        check_eq("w_wr_cyc", wr_c, 7);
        check_eq("w_wdata", wr_data, 64'hCAFE_F00D_FFFF_FFFF);
        check_eq("w_wr_addr", wr_addr, 64'h8);
        check_eq("w_done_cyc", done_c, 8);
        check_eq("w_ready_early", rdy_early, 0);
        check_eq("w_ready_cyc", rdy_c, 9);

        // STURH at an odd address
        run_store(64'h0003, 64'h1111_2222_3333_BEEF, 2'b01, 64'h0, 1);
`ifdef STORE_NARROW_ALIGN_CHECK_EN
        check_eq("hm_err_n", err_n, 1);
        check_eq("hm_err_cyc", err_c, 1);
        check_eq("hm_rd_n", rd_n, 0);
        check_eq("hm_wr_n", wr_n, 0);
        check_eq("hm_done_n", done_n, 0);
        check_eq("hm_ready_cyc", rdy_c, 2);
`else
        check_eq("hm_err_n", err_n, 0);
        check_eq("hm_wdata", wr_data, 64'h0000_0000_BEEF_0000);
        check_eq("hm_wr_addr", wr_addr, 64'h0);
        check_eq("hm_done_cyc", done_c, 4);
`endif

        // STURH into the top lanes, source bits above 16 dropped
        run_store(64'h0006, 64'h1234_5678_9ABC_DEF0, 2'b01, 64'hAAAA_AAAA_AAAA_AAAA, 2);
        check_eq("h_wr_cyc", wr_c, 4);
        check_eq("h_wdata", wr_data, 64'hDEF0_AAAA_AAAA_AAAA);
        check_eq("h_done_cyc", done_c, 5);

        // Reset while waiting for read data
        sif.req_valid = 1'b1;
        sif.req_addr  = 64'h3005;
        sif.req_data  = 64'h77;
        sif.req_size  = 2'b00;
        tick();
        sif.req_valid = 1'b0;
        tick();
        check_eq("r_in_wait_ready", {63'b0, sif.req_ready}, 64'd0);
        rst_n = 1'b0;
        #1;
        check_eq("r_async_ready", {63'b0, sif.req_ready}, 64'd1);
        check_eq("r_async_addr", sif.mem_addr, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        spur_wr = 0;
        sif.mem_rvalid = 1'b1;
        sif.mem_rdata  = 64'h5555_5555_5555_5555;
        for (int c = 0; c < 5; c++) begin
            if (sif.mem_wr || sif.mem_rd || sif.done) spur_wr++;
            tick();
            sif.mem_rvalid = 1'b0;
        end
        check_eq("r_no_strobe", spur_wr, 0);
        check_eq("r_ready_after", {63'b0, sif.req_ready}, 64'd1);
        check_eq("r_wdata", sif.mem_wdata, 64'd0);

        // Spurious read data while idle
        spur_wr = 0;
        sif.mem_rvalid = 1'b1;
        sif.mem_rdata  = 64'h1234;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (sif.mem_wr || sif.mem_rd || sif.done || !sif.req_ready) spur_wr++;
        end
        sif.mem_rvalid = 1'b0;
        check_eq("i_spurious", spur_wr, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
